// File: rtl/cpu_pkg.sv
// Shared CPU-subsystem definitions: on-chip RAM geometry and requester identities.
package cpu_pkg;

    localparam int unsigned RAM_ADDR_W = 14;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned RAM_NUM_REQ = 3;

    // Requester index into the arbiter's packed port vectors.
    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_DMA   = 2'd2
    } req_id_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the first asserted request after ptr_i wins.
module rr_select #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PtrW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic            found;
    logic [PtrW-1:0] idx;

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last winner has lowest priority.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = PtrW'((32'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port RAM between fetch, data and DMA, with an
// RMW lock and a two-stage owner pipeline that routes read data back to its requester.
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = RAM_NUM_REQ,
    parameter int unsigned ADDR_W  = RAM_ADDR_W,
    parameter int unsigned DATA_W  = RAM_DATA_W,
    localparam int unsigned BE_W   = DATA_W / 8,
    localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_lock,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   i_be,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_ram_en,
    output logic [BE_W-1:0]           o_ram_we,
    output logic [ADDR_W-1:0]         o_ram_addr,
    output logic [DATA_W-1:0]         o_ram_wdata,
    input  logic [DATA_W-1:0]         i_ram_rdata
);

    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic               lock_q, lock_d;
    logic [NUM_REQ-1:0] rr_gnt;
    logic               lock_hit;
    logic               any_gnt;
    logic [PtrW-1:0]    win;

    logic               ram_en_q, ram_en_d;
    logic [BE_W-1:0]    ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;

    logic               rd1_q, rd1_d, rd2_q;
    logic [PtrW-1:0]    own1_q, own1_d, own2_q;

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // Grant selection: a locked owner that is still requesting overrides rotation.
    always_comb begin
        lock_hit = lock_q && i_req[ptr_q];
        o_gnt    = lock_hit ? (NUM_REQ'(1) << ptr_q) : rr_gnt;
        any_gnt  = |o_gnt;
        win      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (o_gnt[k]) begin
                win = PtrW'(k);
            end
        end
        ptr_d  = any_gnt ? win : ptr_q;
        // Lock is re-armed only by a grant; an idle or foreign grant releases it.
        lock_d = any_gnt && i_lock[win];
    end

    // Next RAM command and read-tracking stage from the winner's request.
    always_comb begin
        ram_en_d    = any_gnt;
        ram_we_d    = '0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd1_d       = 1'b0;
        own1_d      = win;
        if (any_gnt) begin
            ram_addr_d  = i_addr[win*ADDR_W +: ADDR_W];
            ram_wdata_d = i_wdata[win*DATA_W +: DATA_W];
            if (i_we[win]) begin
                ram_we_d = i_be[win*BE_W +: BE_W];
            end else begin
                rd1_d = 1'b1;
            end
        end
    end

    // Arbitration state, RAM command registers and owner pipeline.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= PtrW'(NUM_REQ - 1);
            lock_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd1_q       <= 1'b0;
            own1_q      <= '0;
            rd2_q       <= 1'b0;
            own2_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd1_q       <= rd1_d;
            own1_q      <= own1_d;
            rd2_q       <= rd1_q;
            own2_q      <= own1_q;
        end
    end

    // Read-data return: RAM output is valid in the cycle after o_ram_en.
    always_comb begin
        o_rvalid = '0;
        if (rd2_q) begin
            o_rvalid[own2_q] = 1'b1;
        end
        o_rdata     = i_ram_rdata;
        o_ram_en    = ram_en_q;
        o_ram_we    = ram_we_q;
        o_ram_addr  = ram_addr_q;
        o_ram_wdata = ram_wdata_q;
    end

endmodule
